// File: rtl/rv_dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rv_dmem_responder                                        |
// | Description : Slow data-memory model for the CPU memory-access stage.  |
// |               Serves one load/store at a time over valid/ready request |
// |               and response channels. It supports byte, halfword and    |
// |               word accesses with RV32I load extension, and returns a   |
// |               response after a programmable latency.                   |
// |               Optional macro DMEM_TOHOST_EN adds a tohost mailbox at   |
// |               byte address 0xFFFF_FFFC.                                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// Lane logic assumes BIN_DIG = 32 (four byte lanes per RAM word).
// DEPTH_WORDS must be at least 2. LATENCY must be in the range 1..15.
module rv_dmem_responder #(
  parameter int BIN_DIG     = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_funct3,
  input  logic [BIN_DIG-1:0] req_addr,
  input  logic [BIN_DIG-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BIN_DIG-1:0] rsp_rdata,
  output logic               rsp_err
`ifdef DMEM_TOHOST_EN
  ,
  output logic               tohost_valid,
  output logic [BIN_DIG-1:0] tohost_data
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [BIN_DIG:0]   c_addr_limit = (BIN_DIG+1)'(4 * DEPTH_WORDS);
  localparam logic [3:0]         c_cnt_init   = 4'(LATENCY - 1);
  localparam logic [BIN_DIG-1:0] c_tohost_adr = ~(BIN_DIG'(3));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BIN_DIG-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [BIN_DIG-1:0] mem_q [DEPTH_WORDS];

  logic               w_accept;
  logic               w_tohost;
  logic               w_f3_ok;
  logic               w_misal;
  logic               w_oor;
  logic               w_err;
  logic               w_wr_en;
  logic [AW-1:0]      w_idx;
  logic [3:0]         w_be;
  logic [BIN_DIG-1:0] w_wdata_lanes;
  logic [BIN_DIG-1:0] w_word;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [BIN_DIG-1:0] w_load;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign w_accept = req_valid && (state_q == IDLE);
  assign w_idx    = req_addr[AW+1:2];
  assign w_word   = mem_q[w_idx];

`ifdef DMEM_TOHOST_EN
  assign w_tohost = req_we && (req_funct3 == 3'b010) && (req_addr == c_tohost_adr);
`else
  assign w_tohost = 1'b0;
`endif

  // Legality, alignment and range of the presented request
  always_comb begin
    w_f3_ok = 1'b0;
    if (req_we) begin
      w_f3_ok = (req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_f3_ok = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_oor   = ({1'b0, req_addr} >= c_addr_limit);
    w_err   = !w_tohost && (!w_f3_ok || w_misal || w_oor);
  end

  assign w_wr_en = w_accept && req_we && !w_err && !w_tohost;

  // Byte-lane enables and lane-replicated store data for the write port
  always_comb begin
    w_be          = 4'b1111;
    w_wdata_lanes = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be          = 4'b0001 << req_addr[1:0];
        w_wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be          = 4'b0011 << req_addr[1:0];
        w_wdata_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be          = 4'b1111;
        w_wdata_lanes = req_wdata;
      end
    endcase
  end

  // Lane selection and RV32I extension of the word read at acceptance
  always_comb begin
    w_byte = w_word[7:0];
    case (req_addr[1:0])
      2'b00:   w_byte = w_word[7:0];
      2'b01:   w_byte = w_word[15:8];
      2'b10:   w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    w_half = req_addr[1] ? w_word[31:16] : w_word[15:0];
    case (req_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      3'b010:  w_load = w_word;
      default: w_load = '0;
    endcase
  end

  // RAM write port; contents survive reset so committed stores persist
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          mem_q[w_idx][8*b +: 8] <= w_wdata_lanes[8*b +: 8];
        end
      end
    end
  end

  // Next-state, latency countdown and response capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          cnt_d   = c_cnt_init;
          err_d   = w_err;
          rdata_d = (w_err || req_we) ? '0 : w_load;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset drops any pending response
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef DMEM_TOHOST_EN
  logic               tohost_valid_q;
  logic [BIN_DIG-1:0] tohost_data_q;

  assign tohost_valid = tohost_valid_q;
  assign tohost_data  = tohost_data_q;

  // Mailbox: latch the stored word and raise a one-cycle strobe
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
    end else begin
      tohost_valid_q <= w_accept && w_tohost;
      if (w_accept && w_tohost) begin
        tohost_data_q <= req_wdata;
      end
    end
  end
`endif

endmodule
`default_nettype wire
